// File: rtl/regfile_sequencer.sv
// regfile_sequencer
// Sequences one two-operand ALU operation against an 8x16 register file that
// has a single combinational read port and a single clocked write port.
// A request is accepted in IDLE and walks through RD_A -> RD_B -> EXEC ->
// (WB) -> DONE, reading both sources one after the other. It then computes the
// result and flags, optionally writes the result back, and pulses done.
// All register-file control outputs decode from the current state only.

module regfile_sequencer #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,

    // request handshake
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [2:0]        in_rd,
    input  logic [2:0]        in_rn,
    input  logic [2:0]        in_rm,
    input  logic              in_wb,

    // register file side
    output logic [2:0]        rf_readnum,
    output logic [2:0]        rf_writenum,
    output logic              rf_write,
    output logic [DATA_W-1:0] rf_data_in,
    input  logic [DATA_W-1:0] rf_data_out,

    // status
    output logic [DATA_W-1:0] result,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_v,
    output logic              done
);

    // ------------------------------------------------------------------
    // State encoding (binary)
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD_A = 3'd1;
    localparam logic [2:0] S_RD_B = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    // Operation codes
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MVN = 2'b11;

    localparam int MSB = DATA_W - 1;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [2:0]        r_state_next;

    logic [1:0]        r_op;
    logic [2:0]        r_rd;
    logic [2:0]        r_rn;
    logic [2:0]        r_rm;
    logic              r_wb;

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;
    logic              r_flag_z;
    logic              r_flag_n;
    logic              r_flag_v;

    // ------------------------------------------------------------------
    // ALU datapath wires
    // ------------------------------------------------------------------
    logic              w_is_sub;
    logic [DATA_W-1:0] w_b_eff;     // B for ADD, ~B for SUB
    logic [DATA_W-1:0] w_sum;       // A + B_eff + carry-in
    logic [DATA_W-1:0] w_and;       // A & B
    logic [DATA_W-1:0] w_not_b;     // ~B
    logic              w_arith_v;   // signed overflow of the adder
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_v;
    logic              w_accept;

    assign w_is_sub = (r_op == OP_SUB);
    assign w_accept = (r_state == S_IDLE) && in_valid;

    // Per-bit lanes: operand inversion for subtract, AND and NOT.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_lane
            assign w_b_eff[gi] = w_is_sub ? ~r_b[gi] : r_b[gi];
            assign w_and[gi]   = r_a[gi] & r_b[gi];
            assign w_not_b[gi] = ~r_b[gi];
        end
    endgenerate

    // SUB is A + ~B + 1: the carry-in is the subtract select itself.
    assign w_sum = r_a + w_b_eff + DATA_W'(w_is_sub);

    // With B already inverted for SUB, both ADD and SUB overflow reduce to:
    // the adder inputs share a sign and the sum's sign differs from A.
    assign w_arith_v = (r_a[MSB] == w_b_eff[MSB]) && (w_sum[MSB] != r_a[MSB]);

    // Select the ALU result and overflow for the latched operation.
    always_comb begin
        w_alu_res = w_sum;
        w_alu_v   = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_alu_res = w_sum;
                w_alu_v   = w_arith_v;
            end
            OP_SUB: begin
                w_alu_res = w_sum;
                w_alu_v   = w_arith_v;
            end
            OP_AND: begin
                w_alu_res = w_and;
                w_alu_v   = 1'b0;
            end
            OP_MVN: begin
                w_alu_res = w_not_b;
                w_alu_v   = 1'b0;
            end
            default: begin
                w_alu_res = w_sum;
                w_alu_v   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // Walk the fixed read/execute/writeback sequence; skip WB for flag-only ops.
    always_comb begin
        r_state_next = r_state;
        case (r_state)
            S_IDLE: r_state_next = in_valid ? S_RD_A : S_IDLE;
            S_RD_A: r_state_next = S_RD_B;
            S_RD_B: r_state_next = S_EXEC;
            S_EXEC: r_state_next = r_wb ? S_WB : S_DONE;
            S_WB:   r_state_next = S_DONE;
            S_DONE: r_state_next = S_IDLE;
            default: r_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    // Advance the FSM and capture request fields, operands, result and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_rd     <= '0;
            r_rn     <= '0;
            r_rm     <= '0;
            r_wb     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
            r_flag_v <= 1'b0;
        end else begin
            r_state <= r_state_next;

            if (w_accept) begin
                r_op <= in_op;
                r_rd <= in_rd;
                r_rn <= in_rn;
                r_rm <= in_rm;
                r_wb <= in_wb;
            end

            if (r_state == S_RD_A) begin
                r_a <= rf_data_out;
            end

            if (r_state == S_RD_B) begin
                r_b <= rf_data_out;
            end

            if (r_state == S_EXEC) begin
                r_result <= w_alu_res;
                r_flag_z <= (w_alu_res == '0);
                r_flag_n <= w_alu_res[MSB];
                r_flag_v <= w_alu_v;
            end
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    // Register-file control and handshake outputs depend on state only.
    always_comb begin
        in_ready    = 1'b0;
        rf_readnum  = 3'd0;
        rf_writenum = 3'd0;
        rf_write    = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: in_ready = 1'b1;
            S_RD_A: rf_readnum = r_rn;
            S_RD_B: rf_readnum = r_rm;
            S_WB: begin
                rf_write    = 1'b1;
                rf_writenum = r_rd;
            end
            S_DONE: done = 1'b1;
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // The write data path always carries the last result.
    assign rf_data_in = r_result;
    assign result     = r_result;
    assign flag_z     = r_flag_z;
    assign flag_n     = r_flag_n;
    assign flag_v     = r_flag_v;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Testbench for regfile_sequencer: a behavioural register file is attached to
// the sequencer, a driver issues directed and random requests and pushes the
// expected outcome into a scoreboard queue, and a monitor checks each done
// pulse and each writeback against the queue.

module tb_regfile_sequencer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [2:0]  in_rd;
    logic [2:0]  in_rn;
    logic [2:0]  in_rm;
    logic        in_wb;
    logic [2:0]  rf_readnum;
    logic [2:0]  rf_writenum;
    logic        rf_write;
    logic [15:0] rf_data_in;
    logic [15:0] rf_data_out;
    logic [15:0] result;
    logic        flag_z;
    logic        flag_n;
    logic        flag_v;
    logic        done;

    // bench-side preload port into the register file
    logic        pre_we;
    logic [2:0]  pre_addr;
    logic [15:0] pre_data;

    int unsigned cyc;
    int          checks;
    int          errors;

    typedef struct {
        logic [2:0]  rd;
        logic        wb;
        logic [15:0] res;
        logic        z;
        logic        n;
        logic        v;
        int unsigned acc_cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] model_rf [8];
    logic [15:0] rf [8];

    regfile_sequencer #(.DATA_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rd       (in_rd),
        .in_rn       (in_rn),
        .in_rm       (in_rm),
        .in_wb       (in_wb),
        .rf_readnum  (rf_readnum),
        .rf_writenum (rf_writenum),
        .rf_write    (rf_write),
        .rf_data_in  (rf_data_in),
        .rf_data_out (rf_data_out),
        .result      (result),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .flag_v      (flag_v),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // register file: combinational read, clocked write
    always @(posedge clk) begin
        if (rf_write) rf[rf_writenum] <= rf_data_in;
        else if (pre_we) rf[pre_addr] <= pre_data;
    end
    assign rf_data_out = rf[rf_readnum];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference ALU from signed/unsigned arithmetic on plain integers.
    function automatic void ref_alu(input logic [1:0] op, input logic [15:0] a,
                                    input logic [15:0] b, output logic [15:0] r,
                                    output logic v);
        int sa;
        int sb;
        int s;
        sa = $signed(a);
        sb = $signed(b);
        s  = 0;
        case (op)
            2'd0: begin s = sa + sb; r = s[15:0]; v = (s > 32767) || (s < -32768); end
            2'd1: begin s = sa - sb; r = s[15:0]; v = (s > 32767) || (s < -32768); end
            2'd2: begin r = a & b; v = 1'b0; end
            default: begin r = ~b; v = 1'b0; end
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Monitor: checks writebacks, done pulses and the busy handshake
    // ------------------------------------------------------------------
    initial begin
        bit   busy;
        int   wr_cnt;
        exp_t e;
        busy   = 0;
        wr_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy   = 0;
                wr_cnt = 0;
            end else begin
                if (busy) chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
                if (rf_write) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_write", 32'd1, 32'd0);
                    end else begin
                        chk("wb_enabled", {31'd0, sb_q[0].wb}, 32'd1);
                        chk("wb_writenum", {29'd0, rf_writenum}, {29'd0, sb_q[0].rd});
                        chk("wb_data", {16'd0, rf_data_in}, {16'd0, sb_q[0].res});
                        wr_cnt++;
                    end
                end
                if (done) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("result", {16'd0, result}, {16'd0, e.res});
                        chk("flag_z", {31'd0, flag_z}, {31'd0, e.z});
                        chk("flag_n", {31'd0, flag_n}, {31'd0, e.n});
                        chk("flag_v", {31'd0, flag_v}, {31'd0, e.v});
                        chk("data_in_eq_result", {16'd0, rf_data_in}, {16'd0, e.res});
                        chk("latency", cyc - e.acc_cyc, e.wb ? 32'd5 : 32'd4);
                        chk("write_count", wr_cnt, {31'd0, e.wb});
                    end
                    wr_cnt = 0;
                    busy   = 0;
                end
                if (in_valid && in_ready) busy = 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic load(input logic [2:0] addr, input logic [15:0] data);
        pre_addr = addr;
        pre_data = data;
        pre_we   = 1'b1;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
        model_rf[addr] = data;
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rn,
                         input logic [2:0] rm, input logic wb, input bit hold,
                         output int unsigned acc);
        exp_t        e;
        logic [15:0] r;
        logic        v;
        bit          got;
        in_op    = op;
        in_rd    = rd;
        in_rn    = rn;
        in_rm    = rm;
        in_wb    = wb;
        in_valid = 1'b1;
        got      = 0;
        acc      = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        ref_alu(op, model_rf[rn], model_rf[rm], r, v);
        e.rd      = rd;
        e.wb      = wb;
        e.res     = r;
        e.z       = (r == 16'd0);
        e.n       = r[15];
        e.v       = v;
        e.acc_cyc = cyc;
        acc       = cyc;
        sb_q.push_back(e);
        if (wb) model_rf[rd] = r;
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int unsigned a1;
        int unsigned a2;
        logic [15:0] saved;
        logic [1:0]  rop;
        cyc      = 0;
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_op    = 2'd0;
        in_rd    = 3'd0;
        in_rn    = 3'd0;
        in_rm    = 3'd0;
        in_wb    = 1'b0;
        pre_we   = 1'b0;
        pre_addr = 3'd0;
        pre_data = 16'd0;

        // reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rf_write", {31'd0, rf_write}, 32'd0);
        chk("rst_readnum", {29'd0, rf_readnum}, 32'd0);
        chk("rst_writenum", {29'd0, rf_writenum}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_flags", {29'd0, flag_z, flag_n, flag_v}, 32'd0);
        chk("rst_data_in", {16'd0, rf_data_in}, 32'd0);
        for (int i = 0; i < 8; i++) load(i[2:0], 16'd0);
        reset = 1'b0;

        // ADD with writeback
        load(3'd1, 16'd5);
        load(3'd2, 16'd3);
        issue(2'd0, 3'd3, 3'd1, 3'd2, 1'b1, 0, a1);
        wait_idle();
        chk("add_R3", {16'd0, rf[3]}, 32'd8);

        // signed overflow
        load(3'd4, 16'h7FFF);
        load(3'd5, 16'h0001);
        issue(2'd0, 3'd6, 3'd4, 3'd5, 1'b1, 0, a1);
        wait_idle();
        chk("ovf_R6", {16'd0, rf[6]}, 32'h8000);

        // compare only (no writeback)
        load(3'd1, 16'd5);
        load(3'd2, 16'd5);
        issue(2'd1, 3'd3, 3'd1, 3'd2, 1'b0, 0, a1);
        wait_idle();
        chk("cmp_R3_kept", {16'd0, rf[3]}, 32'd8);

        // MVN with aliasing, then AND reading the fresh value
        load(3'd7, 16'h00F0);
        issue(2'd3, 3'd7, 3'd0, 3'd7, 1'b1, 0, a1);
        issue(2'd2, 3'd0, 3'd7, 3'd7, 1'b1, 0, a1);
        wait_idle();
        chk("mvn_R7", {16'd0, rf[7]}, 32'hFF0F);
        chk("and_R0", {16'd0, rf[0]}, 32'hFF0F);

        // reset asserted for one cycle while in EXEC
        saved = model_rf[5];
        issue(2'd0, 3'd5, 3'd1, 3'd2, 1'b1, 0, a1);   // now in RD_A
        @(posedge clk); #1;                            // RD_B
        @(posedge clk); #1;                            // EXEC
        reset = 1'b1;
        sb_q.delete();
        model_rf[5] = saved;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_write", {31'd0, rf_write}, 32'd0);
        chk("mid_rst_result", {16'd0, result}, 32'd0);
        chk("mid_rst_flags", {29'd0, flag_z, flag_n, flag_v}, 32'd0);
        chk("mid_rst_dest", {16'd0, rf[5]}, {16'd0, saved});
        @(posedge clk); #1;

        // back-to-back requests with in_valid held high
        issue(2'd0, 3'd1, 3'd2, 3'd3, 1'b1, 1, a1);
        issue(2'd1, 3'd4, 3'd1, 3'd3, 1'b1, 0, a2);
        chk("b2b_spacing", a2 - a1, 32'd6);
        wait_idle();

        // random operations
        for (int i = 0; i < 8; i++) load(i[2:0], 16'($urandom));
        for (int i = 0; i < 48; i++) begin
            if (i % 8 == 7) begin
                wait_idle();
                load(3'($urandom_range(0, 7)), 16'($urandom));
            end
            rop = 2'($urandom_range(0, 3));
            issue(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 1) && (i % 8 != 6) && (i != 47), a1);
        end
        wait_idle();

        for (int i = 0; i < 8; i++) chk($sformatf("final_R%0d", i), {16'd0, rf[i]}, {16'd0, model_rf[i]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // global time bound
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Controls the 8x16 register file: drives readnum, writenum, write and data_in, and consumes data_out.
- Takes one operation request per valid/ready handshake and reads two source registers sequentially through the single read port.
- Performs one ALU operation, writes the result back to the destination register, then pulses done.
- Sits between the instruction decoder/controller and the register file.

Parameters:
- DATA_W, 16, register and datapath width; must match the register file width.

Ports:
- clk  input  1  rising-edge clock; the register file shares this clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  sequencer can accept a request.
- in_op  input  2  operation: 00 ADD, 01 SUB, 10 AND, 11 MVN.
- in_rd  input  3  destination register number.
- in_rn  input  3  first source register (operand A).
- in_rm  input  3  second source register (operand B).
- in_wb  input  1  1 = write the result back; 0 = update flags only.
- rf_readnum  output  3  to register file readnum.
- rf_writenum  output  3  to register file writenum.
- rf_write  output  1  to register file write enable.
- rf_data_in  output  DATA_W  to register file data_in.
- rf_data_out  input  DATA_W  from register file data_out; combinational read.
- result  output  DATA_W  last computed result.
- flag_z  output  1  result zero.
- flag_n  output  1  result MSB.
- flag_v  output  1  signed overflow.
- done  output  1  one-cycle completion pulse.

Behaviour:
- States: IDLE, RD_A, RD_B, EXEC, WB, DONE. The FSM is one-hot or binary (implementer's choice). Register-file control outputs decode from state only (Moore).
- Reset (synchronous, any state): state=IDLE, result=0, flags=0, latched A/B/request fields=0.
- Outputs in the cycle after the reset edge: rf_write=0, done=0, in_ready=1, rf_readnum=0, rf_writenum=0, rf_data_in=result.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch in_op/rd/rn/rm/wb and go to RD_A.
  - in_valid=0: stay in IDLE.
- RD_A: rf_readnum=latched rn; at the edge, A<=rf_data_out; go to RD_B.
- RD_B: rf_readnum=latched rm; at the edge, B<=rf_data_out; go to EXEC.
- EXEC:
  - At the edge, result<=ALU(A,B), and flags update.
  - Next state is WB if wb=1, otherwise DONE.
- WB: rf_write=1, rf_writenum=latched rd, rf_data_in=result for exactly one cycle; go to DONE.
- DONE: done=1 for one cycle; go to IDLE.
- In every state except IDLE, in_ready=0. Requests are ignored and not queued.
- rf_readnum=0 in all states other than RD_A and RD_B. rf_write=0 in all states other than WB. rf_data_in always equals result.
- Latency: with wb=1, done is high in the 5th cycle after the accept edge. With wb=0, done is high in the 4th cycle.
- Throughput: a new request can be accepted in the cycle after DONE, so back-to-back requests take 6 cycles each (wb=1).
- ALU, modulo 2^DATA_W:
  - ADD: A+B.
  - SUB: A-B, computed as A+~B+1.
  - AND: A&B.
  - MVN: ~B; A is ignored.
- Flags:
  - flag_z = (result==0).
  - flag_n = result[DATA_W-1].
  - flag_v for ADD = (A and B have the same sign, and result sign differs from them).
  - flag_v for SUB = (A and B have different signs, and result sign differs from A).
  - flag_v = 0 for AND and MVN.
  - Flags and result hold between operations.
- Hazards:
  - rd may equal rn or rm; both reads complete before WB, so old values are used.
  - rn==rm is legal.
  - The write commits at the WB-cycle edge; a following request reading rd sees the new value.
- Reset mid-operation: abort with no register-file write. Reset during WB takes priority, so the register file may or may not have committed the write at that same edge. The bench must not assert reset coincident with WB.

Test Plan:
- ADD, writeback: R1=5, R2=3; request ADD rd=3 rn=1 rm=2 wb=1 -> rf_write high one cycle with writenum=3, data_in=8; done in 5th cycle; R3=8; Z=0 N=0 V=0.
- Overflow: R4=0x7FFF, R5=0x0001; ADD rd=6 rn=4 rm=5 -> R6=0x8000, N=1, V=1, Z=0.
- Compare only: R1=5, R2=5; SUB rn=1 rm=2 wb=0 -> rf_write never asserted; result=0x0000, Z=1, V=0; done in 4th cycle.
- MVN and aliasing: R7=0x00F0; MVN rd=7 rn=0 rm=7 -> R7=0xFF0F, N=1, V=0. Then AND rd=0 rn=7 rm=7 -> R0=0xFF0F.
- Reset mid-op: assert reset for one cycle while in EXEC -> rf_write stays 0, no done, in_ready=1 the next cycle, result/flags=0, destination register unchanged.
- Handshake: hold in_valid=1 continuously with two distinct requests -> the second is accepted only in IDLE after the first done; in_ready low throughout the busy period; each request completes in 6 cycles.
